// File: rtl/synth_pkg.sv
// Shared types and register map for the multi-voice synthesizer.
// Imported by the wave generator and the top block.
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE,
    SAW,
    TRI,
    NOISE
  } wave_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SAT
  } state_e;

  localparam logic [1:0] REG_STEP = 2'd0;
  localparam logic [1:0] REG_WAVE = 2'd1;
  localparam logic [1:0] REG_VOL  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_GATE  = 0;
  localparam int CTRL_PAN_L = 1;
  localparam int CTRL_PAN_R = 2;

endpackage

// File: rtl/synth_wavegen.sv
// Combinational waveform shaper: phase top bits or noise byte
// to a signed 8-bit sample.
module synth_wavegen
  import synth_pkg::*;
(
  input  logic [1:0] wave,
  input  logic [8:0] phase,
  input  logic [7:0] noise,
  output logic [7:0] sample
);

  logic [7:0] t;
  logic [7:0] u;
  logic [7:0] v;

  assign t = phase[8:1];
  assign u = phase[7:0];
  assign v = phase[8] ? ~u : u;

  always_comb begin
    sample = 8'h00;
    case (wave_e'(wave))
      SQUARE: sample = phase[8] ? 8'h80 : 8'h7f;
      SAW:    sample = t ^ 8'h80;
      TRI:    sample = v ^ 8'h80;
      NOISE:  sample = noise;
    endcase
  end

endmodule

// File: rtl/multi_voice_synth.sv
// N-voice time-multiplexed synthesizer: register file, sample
// divider, voice sequencer, noise LFSR, stereo mixer, saturator.
module multi_voice_synth
  import synth_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ACC_W      = 24,
  parameter int SAMPLE_DIV = 500,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       wr_addr,
  input  logic [ACC_W-1:0] wr_data,
  output logic [15:0]      audio_l,
  output logic [15:0]      audio_r,
  output logic             sample_valid
);

  localparam int AW = 16 + $clog2(CHANNELS) + 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic signed [AW-1:0] MAXV = AW'(32767);
  localparam logic signed [AW-1:0] MINV = -(AW'(32768));

  logic [ACC_W-1:0] step_q  [CHANNELS];
  logic [ACC_W-1:0] phase_q [CHANNELS];
  logic [1:0]       wave_q  [CHANNELS];
  logic [7:0]       vol_q   [CHANNELS];
  logic [2:0]       ctrl_q  [CHANNELS];

  state_e             state_q;
  state_e             state_d;
  logic [DW-1:0]      div_q;
  logic [CH_W-1:0]    vidx;
  logic [14:0]        lfsr;
  logic signed [AW-1:0] acc_l;
  logic signed [AW-1:0] acc_r;

  logic tick;
  logic wr_ok;
  logic last;

  logic [ACC_W-1:0]  cur_p;
  logic [ACC_W-1:0]  cur_step;
  logic [7:0]        cur_vol;
  logic [2:0]        cur_ctrl;
  logic signed [7:0] w;
  logic signed [15:0] w_x;
  logic signed [15:0] v_x;
  logic signed [15:0] prod;
  logic signed [AW-1:0] prod_x;

  assign tick  = (div_q == DW'(SAMPLE_DIV - 1));
  assign wr_ok = wr_en && (int'(wr_ch) < CHANNELS);
  assign last  = (vidx == CH_W'(CHANNELS - 1));

  assign cur_p    = phase_q[vidx];
  assign cur_step = step_q[vidx];
  assign cur_vol  = vol_q[vidx];
  assign cur_ctrl = ctrl_q[vidx];

  synth_wavegen u_wave (
    .wave   (wave_q[vidx]),
    .phase  (cur_p[ACC_W-1 -: 9]),
    .noise  (lfsr[7:0]),
    .sample (w)
  );

  assign w_x    = 16'(w);
  assign v_x    = {8'h00, cur_vol};
  assign prod   = cur_ctrl[CTRL_GATE] ? w_x * v_x : '0;
  assign prod_x = {{(AW-16){prod[15]}}, prod};

  function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
    if (a > MAXV) return 16'h7fff;
    if (a < MINV) return 16'h8000;
    return a[15:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        step_q[i] <= '0;
        wave_q[i] <= '0;
        vol_q[i]  <= '0;
        ctrl_q[i] <= '0;
      end
    end else if (wr_ok) begin
      unique case (wr_addr)
        REG_STEP: step_q[wr_ch] <= wr_data;
        REG_WAVE: wave_q[wr_ch] <= wr_data[1:0];
        REG_VOL:  vol_q[wr_ch]  <= wr_data[7:0];
        REG_CTRL: ctrl_q[wr_ch] <= wr_data[2:0];
      endcase
    end
  end

  // A gated-off voice is parked at phase 0 so re-gating restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) phase_q[i] <= '0;
    end else if (state_q == CALC) begin
      phase_q[vidx] <= cur_ctrl[CTRL_GATE] ? cur_p + cur_step : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = CALC;
      CALC:    if (last) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      lfsr         <= 15'h0001;
      vidx         <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
      case (state_q)
        IDLE: begin
          acc_l <= '0;
          acc_r <= '0;
          vidx  <= '0;
        end
        CALC: begin
          if (cur_ctrl[CTRL_PAN_L]) acc_l <= acc_l + prod_x;
          if (cur_ctrl[CTRL_PAN_R]) acc_r <= acc_r + prod_x;
          vidx <= vidx + CH_W'(1);
        end
        SAT: begin
          audio_l      <= sat16(acc_l);
          audio_r      <= sat16(acc_r);
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_voice_synth.sv
// Bench for multi_voice_synth: directed scenarios plus random register
// traffic, scored against a time-stamped behavioural model.
module tb_multi_voice_synth;

  localparam int CH   = 4;
  localparam int SDIV = 500;
  localparam longint PMOD = 64'd16777216;
  localparam longint HALF = 64'd8388608;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        sample_valid;

  multi_voice_synth #(
    .CHANNELS   (CH),
    .ACC_W      (24),
    .SAMPLE_DIV (SDIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ch; int addr; int data; } wr_t;
  typedef struct { int l; int r; int cyc; } exp_t;

  wr_t    wlog[$];
  exp_t   expq[$];
  int     m_step[CH];
  int     m_wave[CH];
  int     m_vol[CH];
  int     m_ctrl[CH];
  longint m_ph[CH];
  int     m_lfsr = 1;
  int     mc = 0;
  int     t0 = 0;
  bit     pend = 0;

  int nvec = 0;
  int nfail = 0;

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, mc);
    end
  endtask

  function automatic int wave_of(int wv, longint p, int nz);
    int t, u, v, b;
    t = int'(p >> 16) & 255;
    u = int'(p >> 15) & 255;
    b = nz & 255;
    case (wv)
      0: return (p < HALF) ? 127 : -128;
      1: return t - 128;
      2: begin
        v = (p >= HALF) ? 255 - u : u;
        return v - 128;
      end
      default: return (b >= 128) ? b - 256 : b;
    endcase
  endfunction

  function automatic int sat(int a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // Model: writes take effect the cycle after they are stamped; voice k
  // of a sample whose tick is at cycle T is evaluated during cycle T+1+k.
  initial begin
    wr_t   wr;
    exp_t  e;
    int    sl, sr, prod;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mc = 0;
        pend = 0;
        m_lfsr = 1;
        wlog.delete();
        expq.delete();
        for (int i = 0; i < CH; i++) begin
          m_step[i] = 0; m_wave[i] = 0; m_vol[i] = 0;
          m_ctrl[i] = 0; m_ph[i] = 0;
        end
      end else begin
        if (wr_en)
          wlog.push_back('{mc, int'(wr_ch), int'(wr_addr), int'(wr_data)});
        if (mc % SDIV == SDIV - 1) begin
          m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1))
                   & 32'h7fff;
          t0 = mc;
          pend = 1;
        end else if (pend && mc == t0 + CH) begin
          sl = 0;
          sr = 0;
          for (int k = 0; k < CH; k++) begin
            while (wlog.size() > 0 && wlog[0].cyc <= t0 + k) begin
              wr = wlog.pop_front();
              case (wr.addr)
                0: m_step[wr.ch] = wr.data & 32'hffffff;
                1: m_wave[wr.ch] = wr.data & 3;
                2: m_vol[wr.ch]  = wr.data & 255;
                default: m_ctrl[wr.ch] = wr.data & 7;
              endcase
            end
            prod = 0;
            if (m_ctrl[k] & 1) begin
              prod = wave_of(m_wave[k], m_ph[k], m_lfsr) * m_vol[k];
              m_ph[k] = (m_ph[k] + longint'(m_step[k])) % PMOD;
            end else begin
              m_ph[k] = 0;
            end
            if (m_ctrl[k] & 2) sl += prod;
            if (m_ctrl[k] & 4) sr += prod;
          end
          e.l = sat(sl);
          e.r = sat(sr);
          e.cyc = t0 + CH + 2;
          expq.push_back(e);
          pend = 0;
        end
        mc++;
      end
    end
  end

  // Monitor: every sample_valid pulse is matched against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && sample_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          check("mon_l", int'($signed(audio_l)), e.l);
          check("mon_r", int'($signed(audio_r)), e.r);
          check("mon_cycle", mc, e.cyc);
        end
      end
    end
  end

  task automatic wr(input int ch, input int a, input int d);
    wr_en = 1'b1;
    wr_ch = 2'(ch);
    wr_addr = 2'(a);
    wr_data = 24'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 1200);
    if (!sample_valid) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_mod(input int m);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mc % SDIV != m && n < 1200);
    if (mc % SDIV != m) check("wait_mod_timeout", mc % SDIV, m);
  endtask

  initial begin
    int npos, nneg, al;

    // Reset and idle
    repeat (5) @(negedge clk);
    check("rst_l", int'(audio_l), 0);
    check("rst_r", int'(audio_r), 0);
    check("rst_valid", int'(sample_valid), 0);
    reset_n = 1'b1;
    wait_valid("idle0");
    check("first_valid_cycle", mc, 499 + CH + 2);
    wait_valid("idle1");
    check("idle_l", int'(audio_l), 0);

    // Single square voice at 440 Hz
    wr(0, 0, 153791);
    wr(0, 1, 0);
    wr(0, 2, 255);
    wr(0, 3, 7);
    wait_valid("sq0");
    check("sq_first_l", int'($signed(audio_l)), 32385);
    check("sq_first_r", int'($signed(audio_r)), 32385);
    npos = 1;
    nneg = 0;
    for (int i = 1; i < 60; i++) begin
      wait_valid("sq");
      al = int'($signed(audio_l));
      if (al == 32385) npos++;
      if (al == -32640) nneg++;
    end
    check("sq_pos_run", npos, 55);
    check("sq_neg_count", nneg, 5);

    // Gate off, then re-gate
    wr(0, 3, 0);
    wait_valid("gate_off");
    check("gate_off_l", int'($signed(audio_l)), 0);
    wr(0, 3, 7);
    wait_valid("regate");
    check("regate_l", int'($signed(audio_l)), 32385);

    // Saturation with four full-scale squares
    for (int c = 0; c < CH; c++) begin
      wr(c, 0, 0);
      wr(c, 1, 0);
      wr(c, 2, 255);
      wr(c, 3, 7);
    end
    for (int i = 0; i < 3; i++) begin
      wait_valid("sat");
      check("sat_l", int'($signed(audio_l)), 32767);
      check("sat_r", int'($signed(audio_r)), 32767);
    end

    // Pan: left-only saw
    wr(0, 3, 0);
    wr(2, 3, 0);
    wr(3, 3, 0);
    wr(1, 1, 1);
    wr(1, 2, 128);
    wr(1, 3, 3);
    wait_valid("pan");
    check("pan_l", int'($signed(audio_l)), -16384);
    check("pan_r", int'($signed(audio_r)), 0);

    // VOL write on ch3 while ch1 is being processed
    wr(3, 2, 10);
    wr(3, 3, 7);
    wait_valid("mid0");
    check("mid0_l", int'($signed(audio_l)), -15114);
    check("mid0_r", int'($signed(audio_r)), 1270);
    wait_mod(1);
    wr(3, 2, 100);
    wait_valid("mid1");
    check("mid1_l", int'($signed(audio_l)), -3684);
    check("mid1_r", int'($signed(audio_r)), 12700);

    // Reset in the middle of CALC
    wait_mod(2);
    reset_n = 1'b0;
    #1;
    check("abort_l", int'(audio_l), 0);
    check("abort_r", int'(audio_r), 0);
    check("abort_valid", int'(sample_valid), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Random register traffic at arbitrary times
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(31) == 0)
        wr($urandom_range(CH - 1), $urandom_range(3),
           int'($urandom & 32'hffffff));
      else
        @(negedge clk);
    end

    repeat (1200) @(negedge clk);
    check("drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/multi_voice_synth.md
# multi_voice_synth

Parametrised successor to the single-voice square-wave synthesizer: N time-multiplexed voices, each with a phase accumulator, selectable waveform (square, saw, triangle, noise), 8-bit volume, gate and L/R pan. A register-write port configures voices. Outputs are saturated 16-bit signed stereo samples at a fixed sample rate and drive `AUDIO_L`/`AUDIO_R` directly, with `AUDIO_S = 1`.

## Interface
- `CHANNELS`, 4: voice count, 1..16.
- `ACC_W`, 24: phase accumulator width, 12..32.
- `SAMPLE_DIV`, 500: clocks per output sample; 24 MHz / 500 = 48 kHz. Must be ≥ `CHANNELS`+3.

- `clk`  in  1  system clock (clk_sys, 24 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  register write strobe; one write per cycle.
- `wr_ch`  in  $clog2(CHANNELS)  target voice; out-of-range writes are ignored.
- `wr_addr`  in  2  register select: 0 STEP, 1 WAVE, 2 VOL, 3 CTRL.
- `wr_data`  in  ACC_W  write data. STEP uses `[ACC_W-1:0]`, WAVE uses `[1:0]`, VOL uses `[7:0]`, CTRL uses `[2:0]` = {pan_r, pan_l, gate}.
- `audio_l`, `audio_r`  out  16  signed mixed samples.
- `sample_valid`  out  1  one-cycle pulse when `audio_l`/`audio_r` update.

## Operation
- Register file: per-voice STEP, WAVE, VOL, CTRL, plus a phase accumulator.
  - All registers reset to 0.
  - Writes take effect at the next clock edge.
  - A voice already processed in the current sample sees a new value only on the next sample.
- Sample divider: counts 0..`SAMPLE_DIV`-1 and wraps. At count `SAMPLE_DIV`-1 it issues `tick`.
- FSM states: IDLE → CALC → SAT → IDLE.
  - IDLE: wait for `tick`, clear the L/R accumulators, go to CALC.
  - CALC: processes voice k on the k-th CALC cycle, k = 0..`CHANNELS`-1.
    - Compute signed 8-bit wave `w` from the current phase `p`.
    - Product = `w` × VOL, signed 16-bit.
    - Add the product to acc_L if pan_l is set, and to acc_R if pan_r is set.
    - Then update the phase: p ← p + STEP, mod 2^ACC_W.
    - If gate = 0: product is 0 and p ← 0.
  - SAT: clamp acc_L and acc_R to [-32768, 32767], register them to the outputs, pulse `sample_valid`, return to IDLE.
- Waveforms (t = p[ACC_W-1 -: 8]):
  - Square: p MSB = 0 → +127, otherwise -128.
  - Saw: t ^ 8'h80, interpreted as signed.
  - Triangle: u = p[ACC_W-2 -: 8]; v = p MSB ? ~u : u; w = v ^ 8'h80.
  - Noise: low 8 bits of a shared 15-bit LFSR.
    - Taps x^15+x^14+1, seed 15'h0001 at reset.
    - Advances once per `tick`.
- Accumulator width: 16 + $clog2(CHANNELS) + 1 bits, signed. Overflow is impossible before SAT.
- Step for frequency f: STEP = round(f·2^ACC_W / 48000). For 440 Hz at `ACC_W`=24, STEP = 153791.

## Timing
- Reset values: `audio_l` = `audio_r` = 0, `sample_valid` = 0, FSM in IDLE, divider at 0, LFSR at 15'h0001.
- Reset asserted mid-CALC aborts the sample. No `sample_valid` fires for it.
- Latency: `tick` at cycle T; voices processed at T+1..T+`CHANNELS`; SAT at T+`CHANNELS`+1; outputs and `sample_valid` at T+`CHANNELS`+2.
- `sample_valid` period is exactly `SAMPLE_DIV` cycles.
- Outputs hold their value between pulses.
- No backpressure: the consumer must sample the outputs on `sample_valid` or treat them as level outputs.

## Structure
- Package `synth_pkg`:
  - `wave_e` enum {SQUARE, SAW, TRI, NOISE}.
  - Register address constants REG_STEP, REG_WAVE, REG_VOL, REG_CTRL.
  - CTRL bit indices.
- Sub-module `synth_wavegen`: combinational, maps (wave_e, phase top 9 bits, lfsr byte) to the signed 8-bit sample.
- Top block holds the register file, divider, FSM, LFSR, mixer and saturator.

## Test plan
- Reset / idle: hold `reset_n`=0, then release with no writes. Require `audio_l`=`audio_r`=0 and a `sample_valid` pulse every 500 cycles, the first at cycle 499+`CHANNELS`+2.
- Single square voice: ch0 STEP=153791, WAVE=SQUARE, VOL=255, CTRL=3'b111. First sample is +32385 on both channels. Output then alternates between +32385 and -32640, with 109 or 110 samples per period averaging 109.09.
- Saturation: all 4 voices square, VOL=255, STEP=0, gated, both pans. Require both outputs = 32767 every sample.
- Pan: ch1 saw, VOL=128, CTRL=3'b011 (left only). Require `audio_r`=0. First `audio_l` = -128×128 = -16384.
- Gate off: gate a running voice off between samples. The next sample contributes 0 and the phase reads 0. Re-gate: the first sample is the phase-0 value again (+127×VOL for square).
- Mid-operation events: write VOL on ch3 during ch1's CALC cycle; it must apply in the same sample. Assert `reset_n` during CALC; outputs must go to 0 immediately and no `sample_valid` may follow for that sample.
